// File: rtl/tnn_pkg.sv
// rtl/tnn_pkg.sv - shared timing constants and types for the temporal neural blocks
package tnn_pkg;

    localparam int GAMMA_CYCLE_WIDTH_DEF = 16;
    localparam int PULSE_WIDTH_DEF       = 8;
    localparam int VAL_W                 = $clog2(GAMMA_CYCLE_WIDTH_DEF);

    typedef logic [VAL_W-1:0] spike_time_t;

    // Latest onset that still lets a full-width pulse end inside the frame.
    function automatic int max_val(input int gamma_cycle_width, input int pulse_width);
        return gamma_cycle_width - 1 - pulse_width;
    endfunction

endpackage

// File: rtl/gamma_phase_counter.sv
// rtl/gamma_phase_counter.sv - free-running gamma phase counter with registered grst
module gamma_phase_counter #(
    parameter int GAMMA_CYCLE_WIDTH = tnn_pkg::GAMMA_CYCLE_WIDTH_DEF,
    localparam int PH_W = $clog2(GAMMA_CYCLE_WIDTH)
) (
    input  logic            aclk,
    input  logic            rst_n,
    output logic [PH_W-1:0] ph,
    output logic [PH_W-1:0] ph_next,
    output logic            wrap,
    output logic            grst
);

    localparam logic [PH_W-1:0] LAST = PH_W'(GAMMA_CYCLE_WIDTH - 1);

    assign wrap    = (ph == LAST);
    assign ph_next = wrap ? '0 : ph + PH_W'(1);

    // Parking on the last phase during reset makes the first edge a frame boundary.
    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) begin
            ph   <= LAST;
            grst <= 1'b0;
        end else begin
            ph   <= ph_next;
            grst <= (ph_next == '0);
        end
    end

endmodule

// File: rtl/temporal_spike_encoder.sv
// rtl/temporal_spike_encoder.sv - buffers input vectors and replays them as pulse-width spikes
module temporal_spike_encoder import tnn_pkg::*; #(
    parameter int N_CH              = 2,
    parameter int GAMMA_CYCLE_WIDTH = GAMMA_CYCLE_WIDTH_DEF,
    parameter int PULSE_WIDTH       = PULSE_WIDTH_DEF,
    localparam int VW               = $clog2(GAMMA_CYCLE_WIDTH)
) (
    input  logic               aclk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N_CH*VW-1:0] in_val,
    input  logic [N_CH-1:0]    in_null,
    output logic               grst,
    output logic [N_CH-1:0]    spike
);

    localparam logic [VW-1:0] MAX_V  = VW'(max_val(GAMMA_CYCLE_WIDTH, PULSE_WIDTH));
    localparam logic [VW:0]   ONE_X  = (VW+1)'(1);
    localparam logic [VW:0]   PW_X   = (VW+1)'(PULSE_WIDTH);

    logic [VW-1:0]      ph;
    logic [VW-1:0]      ph_next;
    logic               wrap;

    logic [N_CH*VW-1:0] pend_val;
    logic [N_CH-1:0]    pend_null;
    logic               pend_full;
    logic [N_CH*VW-1:0] act_val;
    logic [N_CH-1:0]    act_null;
    logic [N_CH*VW-1:0] act_val_next;
    logic [N_CH-1:0]    act_null_next;
    logic [N_CH*VW-1:0] sat_val;
    logic [N_CH-1:0]    spike_next;
    logic               accept;

    gamma_phase_counter #(
        .GAMMA_CYCLE_WIDTH(GAMMA_CYCLE_WIDTH)
    ) u_phase (
        .aclk   (aclk),
        .rst_n  (rst_n),
        .ph     (ph),
        .ph_next(ph_next),
        .wrap   (wrap),
        .grst   (grst)
    );

    assign in_ready = !pend_full || wrap;
    assign accept   = in_valid && in_ready;

    // A frame with nothing pending replays as all-null rather than repeating.
    always_comb begin
        act_val_next  = act_val;
        act_null_next = act_null;
        if (wrap) begin
            if (pend_full) begin
                act_val_next  = pend_val;
                act_null_next = pend_null;
            end else begin
                act_val_next  = '0;
                act_null_next = '1;
            end
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [VW-1:0] raw;
        logic [VW-1:0] onset;
        logic [VW:0]   lo;
        logic [VW:0]   hi;
        logic [VW:0]   ph_x;

        assign raw   = in_val[i*VW +: VW];
        assign sat_val[i*VW +: VW] = (raw > MAX_V) ? MAX_V : raw;
        assign onset = act_val_next[i*VW +: VW];
        assign lo    = {1'b0, onset} + ONE_X;
        assign hi    = {1'b0, onset} + PW_X;
        assign ph_x  = {1'b0, ph_next};
        assign spike_next[i] = !act_null_next[i] && (ph_x >= lo) && (ph_x <= hi);
    end

    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) begin
            pend_val  <= '0;
            pend_null <= '1;
            pend_full <= 1'b0;
            act_val   <= '0;
            act_null  <= '1;
            spike     <= '0;
        end else begin
            act_val  <= act_val_next;
            act_null <= act_null_next;
            spike    <= spike_next;
            if (accept) begin
                pend_val  <= sat_val;
                pend_null <= in_null;
                pend_full <= 1'b1;
            end else if (wrap) begin
                pend_full <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_temporal_spike_encoder.sv
// tb/tb_temporal_spike_encoder.sv - directed self-checking bench for temporal_spike_encoder
module tb_temporal_spike_encoder;

    logic       aclk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_val;
    logic [1:0] in_null;
    logic       grst;
    logic [1:0] spike;

    int checks;
    int failures;
    int ph_m;

    temporal_spike_encoder #(
        .N_CH(2),
        .GAMMA_CYCLE_WIDTH(16),
        .PULSE_WIDTH(8)
    ) dut (
        .aclk    (aclk),
        .rst_n   (rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_val  (in_val),
        .in_null (in_null),
        .grst    (grst),
        .spike   (spike)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s ph=%0d observed=%0h expected=%0h", tag, ph_m, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge aclk);
        ph_m = (ph_m + 1) % 16;
        @(negedge aclk);
        chk("grst", 32'(grst), 32'(ph_m == 0));
    endtask

    task automatic goto_ph(input int p);
        for (int i = 0; i < 17; i++) begin
            if (ph_m == p) break;
            step();
        end
    endtask

    task automatic send(input int a, input int b, input logic [1:0] n);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_val   = {4'(b), 4'(a)};
        in_null  = n;
        for (int i = 0; i < 40; i++) begin
            if (in_ready) begin
                step();
                done = 1'b1;
                break;
            end
            step();
        end
        in_valid = 1'b0;
        chk("send_accepted", 32'(done), 32'd1);
    endtask

    task automatic check_frame(input int lo0, input bit v0, input int lo1, input bit v1);
        for (int p = 0; p < 16; p++) begin
            chk("spike0", 32'(spike[0]), 32'(v0 && p >= lo0 && p <= lo0 + 7));
            chk("spike1", 32'(spike[1]), 32'(v1 && p >= lo1 && p <= lo1 + 7));
            if (p < 15) step();
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        ph_m     = 15;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_val   = '0;
        in_null  = '0;
        @(negedge aclk);
        @(negedge aclk);
        chk("reset_grst", 32'(grst), 32'd0);
        chk("reset_spike", 32'(spike), 32'd0);
        chk("reset_ready", 32'(in_ready), 32'd1);

        // 1: idle frames, grst period 16, no spikes
        rst_n = 1'b1;
        ph_m  = 15;
        for (int i = 0; i < 48; i++) begin
            step();
            chk("idle_spike", 32'(spike), 32'd0);
        end

        // 2: a=2, b=4
        goto_ph(2);
        send(2, 4, 2'b00);
        goto_ph(0);
        check_frame(3, 1, 5, 1);

        // 3: saturation a=12, b=7 -> both onset 7
        goto_ph(1);
        send(12, 7, 2'b00);
        goto_ph(0);
        check_frame(8, 1, 8, 1);
        step();
        chk("sat_low_at_ph0", 32'(spike), 32'd0);

        // 4: channel 1 null
        goto_ph(1);
        send(3, 5, 2'b10);
        goto_ph(0);
        check_frame(4, 1, 0, 0);

        // 5: back-to-back offers at ph 5
        goto_ph(5);
        in_valid = 1'b1;
        in_val   = {4'd2, 4'd1};
        in_null  = 2'b00;
        chk("b2b_first_ready", 32'(in_ready), 32'd1);
        step();
        in_val = {4'd0, 4'd6};
        for (int i = 0; i < 16; i++) begin
            if (ph_m == 15) break;
            chk("b2b_ready_low", 32'(in_ready), 32'd0);
            step();
        end
        chk("b2b_ready_ph15", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        check_frame(2, 1, 3, 1);
        step();
        check_frame(7, 1, 1, 1);

        // 6: reset mid-pulse with a pending vector
        goto_ph(1);
        send(5, 1, 2'b00);
        goto_ph(0);
        goto_ph(2);
        send(3, 3, 2'b00);
        goto_ph(6);
        chk("pre_reset_spike", 32'(spike), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("async_spike", 32'(spike), 32'd0);
        chk("async_grst", 32'(grst), 32'd0);
        chk("async_ready", 32'(in_ready), 32'd1);
        @(negedge aclk);
        rst_n = 1'b1;
        ph_m  = 15;
        chk("post_reset_ready", 32'(in_ready), 32'd1);
        step();
        check_frame(0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
